// File: rtl/axil_read_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : axil_read_arbiter
// Description : Round-robin arbiter sharing one AXI-Lite read channel among
//               NUM_MASTERS requesters, with downstream response timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module axil_read_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                          S_AXIL_ACLK,
    input  logic                          S_AXIL_ARESETn,
    input  logic [NUM_MASTERS-1:0]        S_AXIL_ARVALID,
    output logic [NUM_MASTERS-1:0]        S_AXIL_ARREADY,
    input  logic [NUM_MASTERS*ADDR_W-1:0] S_AXIL_ARADDR,
    input  logic [NUM_MASTERS*3-1:0]      S_AXIL_ARPROT,
    output logic [NUM_MASTERS-1:0]        S_AXIL_RVALID,
    input  logic [NUM_MASTERS-1:0]        S_AXIL_RREADY,
    output logic [DATA_W-1:0]             S_AXIL_RDATA,
    output logic [1:0]                    S_AXIL_RRESP,
    output logic                          M_AXIL_ARVALID,
    input  logic                          M_AXIL_ARREADY,
    output logic [ADDR_W-1:0]             M_AXIL_ARADDR,
    output logic [2:0]                    M_AXIL_ARPROT,
    input  logic                          M_AXIL_RVALID,
    output logic                          M_AXIL_RREADY,
    input  logic [DATA_W-1:0]             M_AXIL_RDATA,
    input  logic [1:0]                    M_AXIL_RRESP
);

    localparam int GW = $clog2(NUM_MASTERS);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ADDR  = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_RESP  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    logic [2:0]             state;
    logic [2:0]             state_nxt;
    logic [GW-1:0]          last_grant;
    logic [GW-1:0]          grant;
    logic [GW-1:0]          winner;
    logic                   win_found;
    logic [NUM_MASTERS-1:0] grant_oh;
    logic [CW-1:0]          tmo_cnt;
    logic                   timed_out;

    logic ar_hs_up;
    logic ar_hs_dn;
    logic r_hs_dn;
    logic tmo_hit;
    logic r_hs_up;
    logic drain_done;

    // Round-robin search starting just after the last granted requester
    always_comb begin
        logic [GW-1:0] idx;
        idx       = '0;
        winner    = '0;
        win_found = 1'b0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx = GW'((int'(last_grant) + k) % NUM_MASTERS);
            if (!win_found && S_AXIL_ARVALID[idx]) begin
                win_found = 1'b1;
                winner    = idx;
            end
        end
    end

    assign grant_oh   = NUM_MASTERS'(1) << grant;
    assign ar_hs_up   = (state == ST_IDLE) && win_found;
    assign ar_hs_dn   = (state == ST_ADDR) && M_AXIL_ARREADY;
    assign r_hs_dn    = (state == ST_DATA) && M_AXIL_RVALID;
    // A real beat wins over a timeout landing in the same cycle
    assign tmo_hit    = (state == ST_DATA) && !M_AXIL_RVALID && (TIMEOUT_CYCLES != 0)
                        && (tmo_cnt == TO_LAST);
    assign r_hs_up    = (state == ST_RESP) && S_AXIL_RREADY[grant];
    assign drain_done = (state == ST_DRAIN) && M_AXIL_RVALID;

    always_ff @(posedge S_AXIL_ACLK or negedge S_AXIL_ARESETn) begin
        if (!S_AXIL_ARESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (ar_hs_up)   state_nxt = ST_ADDR;
            ST_ADDR:  if (ar_hs_dn)   state_nxt = ST_DATA;
            ST_DATA:  if (r_hs_dn || tmo_hit) state_nxt = ST_RESP;
            ST_RESP:  if (r_hs_up)    state_nxt = timed_out ? ST_DRAIN : ST_IDLE;
            ST_DRAIN: if (drain_done) state_nxt = ST_IDLE;
            default:                  state_nxt = ST_IDLE;
        endcase
    end

    // Upstream ARREADY is held low while reset is asserted so every output reads 0
    always_comb begin
        S_AXIL_ARREADY = '0;
        M_AXIL_RREADY  = 1'b0;
        if (S_AXIL_ARESETn && ar_hs_up) begin
            S_AXIL_ARREADY[winner] = 1'b1;
        end
        if ((state == ST_DATA) || (state == ST_DRAIN)) begin
            M_AXIL_RREADY = 1'b1;
        end
    end

    always_ff @(posedge S_AXIL_ACLK or negedge S_AXIL_ARESETn) begin
        if (!S_AXIL_ARESETn) begin
            last_grant     <= GW'(NUM_MASTERS - 1);
            grant          <= '0;
            M_AXIL_ARVALID <= 1'b0;
            M_AXIL_ARADDR  <= '0;
            M_AXIL_ARPROT  <= '0;
            S_AXIL_RVALID  <= '0;
            S_AXIL_RDATA   <= '0;
            S_AXIL_RRESP   <= '0;
            tmo_cnt        <= '0;
            timed_out      <= 1'b0;
        end else begin
            if (ar_hs_up) begin
                M_AXIL_ARADDR  <= S_AXIL_ARADDR[int'(winner)*ADDR_W +: ADDR_W];
                M_AXIL_ARPROT  <= S_AXIL_ARPROT[int'(winner)*3 +: 3];
                grant          <= winner;
                last_grant     <= winner;
                M_AXIL_ARVALID <= 1'b1;
            end
            if (ar_hs_dn) begin
                M_AXIL_ARVALID <= 1'b0;
                tmo_cnt        <= '0;
            end
            if ((state == ST_DATA) && (tmo_cnt != '1)) begin
                tmo_cnt <= tmo_cnt + CW'(1);
            end
            if (r_hs_dn) begin
                S_AXIL_RDATA  <= M_AXIL_RDATA;
                S_AXIL_RRESP  <= M_AXIL_RRESP;
                S_AXIL_RVALID <= grant_oh;
            end else if (tmo_hit) begin
                S_AXIL_RDATA  <= '0;
                S_AXIL_RRESP  <= 2'b10;
                S_AXIL_RVALID <= grant_oh;
                timed_out     <= 1'b1;
            end
            if (r_hs_up) begin
                S_AXIL_RVALID <= '0;
            end
            if (drain_done) begin
                timed_out <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axil_read_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_axil_read_arbiter
// Description : Self-checking bench: vector table, corner sequences, random.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_read_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   s_arvalid;
    logic [3:0]   s_arready;
    logic [127:0] s_araddr;
    logic [11:0]  s_arprot;
    logic [3:0]   s_rvalid;
    logic [3:0]   s_rready;
    logic [31:0]  s_rdata;
    logic [1:0]   s_rresp;
    logic         m_arvalid;
    logic         m_arready;
    logic [31:0]  m_araddr;
    logic [2:0]   m_arprot;
    logic         m_rvalid;
    logic         m_rready;
    logic [31:0]  m_rdata;
    logic [1:0]   m_rresp;

    int checks;
    int failures;
    int model_last;
    logic [31:0] addr_tab [4];
    logic [2:0]  prot_tab [4];

    typedef struct {
        logic [3:0] mask;
        int         grant;
        int         ar_dly;
        int         r_dly;
        int         rr_dly;
    } vec_t;
    vec_t vecs [15];

    axil_read_arbiter #(
        .NUM_MASTERS   (4),
        .ADDR_W        (32),
        .DATA_W        (32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .S_AXIL_ACLK   (clk),
        .S_AXIL_ARESETn(rst_n),
        .S_AXIL_ARVALID(s_arvalid),
        .S_AXIL_ARREADY(s_arready),
        .S_AXIL_ARADDR (s_araddr),
        .S_AXIL_ARPROT (s_arprot),
        .S_AXIL_RVALID (s_rvalid),
        .S_AXIL_RREADY (s_rready),
        .S_AXIL_RDATA  (s_rdata),
        .S_AXIL_RRESP  (s_rresp),
        .M_AXIL_ARVALID(m_arvalid),
        .M_AXIL_ARREADY(m_arready),
        .M_AXIL_ARADDR (m_araddr),
        .M_AXIL_ARPROT (m_arprot),
        .M_AXIL_RVALID (m_rvalid),
        .M_AXIL_RREADY (m_rready),
        .M_AXIL_RDATA  (m_rdata),
        .M_AXIL_RRESP  (m_rresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arbitration rule: first requester after the last grant, cyclically
    function automatic int model_pick(input logic [3:0] mask);
        int idx;
        for (int k = 1; k <= 4; k++) begin
            idx = (model_last + k) % 4;
            if (mask[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic load_addrs();
        for (int i = 0; i < 4; i++) begin
            addr_tab[i] = $urandom & 32'hFFFF_FFFC;
            prot_tab[i] = 3'($urandom_range(0, 7));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_s_arready"}, 64'(s_arready), 64'd0);
        chk({tag, "_s_rvalid"},  64'(s_rvalid),  64'd0);
        chk({tag, "_s_rdata"},   64'(s_rdata),   64'd0);
        chk({tag, "_s_rresp"},   64'(s_rresp),   64'd0);
        chk({tag, "_m_arvalid"}, 64'(m_arvalid), 64'd0);
        chk({tag, "_m_araddr"},  64'(m_araddr),  64'd0);
        chk({tag, "_m_arprot"},  64'(m_arprot),  64'd0);
        chk({tag, "_m_rready"},  64'(m_rready),  64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_arvalid = '0; s_rready = '0; m_arready = 1'b0; m_rvalid = 1'b0;
        #1;
        chk_all_zero("reset");
        tick();
        tick();
        rst_n = 1'b1;
        model_last = 3;
        #1;
    endtask

    // One complete transaction; caller is in IDLE at posedge+1
    task automatic do_txn(input logic [3:0] mask, input int g, input int ar_dly,
                          input int r_dly, input int rr_dly,
                          input logic [31:0] data, input logic [1:0] resp);
        logic [3:0] oh;
        logic [3:0] others;
        oh     = 4'b0001 << g;
        others = ~oh;
        for (int i = 0; i < 4; i++) begin
            s_araddr[i*32 +: 32] = addr_tab[i];
            s_arprot[i*3 +: 3]   = prot_tab[i];
        end
        s_arvalid = mask;
        #1;
        chk("arready_grant", 64'(s_arready), 64'(oh));
        chk("m_arvalid_idle", 64'(m_arvalid), 64'd0);
        tick();
        s_arvalid = others;
        s_araddr  = ~s_araddr;
        s_arprot  = ~s_arprot;
        #1;
        chk("m_arvalid_latency", 64'(m_arvalid), 64'd1);
        chk("m_araddr", 64'(m_araddr), 64'(addr_tab[g]));
        chk("m_arprot", 64'(m_arprot), 64'(prot_tab[g]));
        chk("arready_addr", 64'(s_arready), 64'd0);
        for (int k = 0; k < ar_dly; k++) begin
            tick();
            chk("m_arvalid_hold", 64'(m_arvalid), 64'd1);
            chk("m_araddr_hold", 64'(m_araddr), 64'(addr_tab[g]));
            chk("arready_addr_wait", 64'(s_arready), 64'd0);
        end
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        m_rdata   = $urandom;
        #1;
        chk("m_arvalid_drop", 64'(m_arvalid), 64'd0);
        chk("m_rready_data", 64'(m_rready), 64'd1);
        for (int k = 0; k < r_dly; k++) begin
            chk("s_rvalid_wait", 64'(s_rvalid), 64'd0);
            chk("m_rready_wait", 64'(m_rready), 64'd1);
            tick();
        end
        m_rvalid = 1'b1;
        m_rdata  = data;
        m_rresp  = resp;
        tick();
        m_rvalid = 1'b0;
        m_rdata  = ~data;
        m_rresp  = ~resp;
        s_rready = others;
        #1;
        chk("s_rvalid_route", 64'(s_rvalid), 64'(oh));
        chk("s_rdata", 64'(s_rdata), 64'(data));
        chk("s_rresp", 64'(s_rresp), 64'(resp));
        chk("m_rready_resp", 64'(m_rready), 64'd0);
        for (int k = 0; k < rr_dly; k++) begin
            tick();
            chk("s_rvalid_hold", 64'(s_rvalid), 64'(oh));
            chk("s_rdata_hold", 64'(s_rdata), 64'(data));
            chk("s_rresp_hold", 64'(s_rresp), 64'(resp));
            chk("arready_resp", 64'(s_arready), 64'd0);
        end
        s_rready = oh;
        tick();
        s_rready  = '0;
        s_arvalid = '0;
        #1;
        chk("s_rvalid_clear", 64'(s_rvalid), 64'd0);
        chk("arready_idle", 64'(s_arready), 64'd0);
        model_last = g;
    endtask

    initial begin
        logic [3:0] rmask;
        int         rg;
        checks = 0; failures = 0; model_last = 3;
        s_araddr = '0; s_arprot = '0; m_rdata = '0; m_rresp = '0;

        vecs[0]  = '{4'b1111, 0, 0, 0, 0};
        vecs[1]  = '{4'b1110, 1, 1, 1, 1};
        vecs[2]  = '{4'b1100, 2, 0, 7, 0};
        vecs[3]  = '{4'b1000, 3, 3, 2, 5};
        vecs[4]  = '{4'b0110, 1, 0, 0, 0};
        vecs[5]  = '{4'b0110, 2, 2, 3, 1};
        vecs[6]  = '{4'b0110, 1, 0, 6, 2};
        vecs[7]  = '{4'b0110, 2, 1, 0, 0};
        vecs[8]  = '{4'b1001, 3, 0, 1, 0};
        vecs[9]  = '{4'b1001, 0, 0, 0, 3};
        vecs[10] = '{4'b1001, 3, 0, 7, 0};
        vecs[11] = '{4'b0101, 0, 1, 1, 1};
        vecs[12] = '{4'b0101, 2, 0, 0, 0};
        vecs[13] = '{4'b0011, 0, 2, 2, 2};
        vecs[14] = '{4'b0010, 1, 0, 0, 0};

        do_reset();

        // Single read from requester 0
        load_addrs();
        addr_tab[0] = 32'h0000_0010;
        do_txn(4'b0001, 0, 0, 2, 0, 32'hDEADBEEF, 2'b00);

        do_reset();
        for (int v = 0; v < 15; v++) begin
            load_addrs();
            do_txn(vecs[v].mask, vecs[v].grant, vecs[v].ar_dly, vecs[v].r_dly,
                   vecs[v].rr_dly, $urandom, 2'($urandom_range(0, 3)));
        end

        // Downstream silent: SLVERR after timeout, late beat drained
        load_addrs();
        s_arvalid = 4'b0100;
        #1;
        chk("to_arready", 64'(s_arready), 64'b0100);
        tick();
        s_arvalid = '0;
        m_arready = 1'b1;
        #1;
        chk("to_m_arvalid", 64'(m_arvalid), 64'd1);
        tick();
        m_arready = 1'b0;
        m_rdata   = 32'hBAD0_BAD0;
        m_rresp   = 2'b01;
        #1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k < 8) begin
                chk("to_s_rvalid_wait", 64'(s_rvalid), 64'd0);
                chk("to_m_rready_wait", 64'(m_rready), 64'd1);
            end else begin
                chk("to_s_rvalid", 64'(s_rvalid), 64'b0100);
                chk("to_rdata", 64'(s_rdata), 64'd0);
                chk("to_rresp", 64'(s_rresp), 64'd2);
                chk("to_m_rready_resp", 64'(m_rready), 64'd0);
            end
        end
        s_arvalid = 4'b0001;
        s_rready  = 4'b0100;
        tick();
        s_rready = '0;
        #1;
        chk("drain_s_rvalid", 64'(s_rvalid), 64'd0);
        chk("drain_arready", 64'(s_arready), 64'd0);
        chk("drain_m_rready", 64'(m_rready), 64'd1);
        tick();
        chk("drain_arready2", 64'(s_arready), 64'd0);
        m_rvalid = 1'b1;
        m_rdata  = 32'h1234_5678;
        m_rresp  = 2'b00;
        tick();
        m_rvalid = 1'b0;
        #1;
        chk("drain_not_forwarded", 64'(s_rvalid), 64'd0);
        chk("drain_idle_arready", 64'(s_arready), 64'b0001);
        chk("drain_m_rready_off", 64'(m_rready), 64'd0);
        model_last = 2;
        s_arvalid  = '0;
        load_addrs();
        do_txn(4'b0001, 0, 1, 3, 1, 32'hCAFE_F00D, 2'b01);

        // Randomized traffic against the arbitration model
        for (int n = 0; n < 40; n++) begin
            rmask = 4'($urandom_range(1, 15));
            rg    = model_pick(rmask);
            load_addrs();
            do_txn(rmask, rg, $urandom_range(0, 4), $urandom_range(0, 7),
                   $urandom_range(0, 4), $urandom, 2'($urandom_range(0, 3)));
        end

        // Reset while waiting for downstream data
        load_addrs();
        for (int i = 0; i < 4; i++) begin
            s_araddr[i*32 +: 32] = addr_tab[i] | 32'h1000;
        end
        s_arvalid = 4'b0010;
        tick();
        s_arvalid = '0;
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        tick();
        tick();
        chk("pre_reset_m_rready", 64'(m_rready), 64'd1);
        s_arvalid = 4'b1000;
        rst_n     = 1'b0;
        #1;
        chk_all_zero("async_reset");
        tick();
        rst_n      = 1'b1;
        s_arvalid  = '0;
        model_last = 3;
        #1;
        load_addrs();
        do_txn(4'b1000, 3, 0, 1, 0, $urandom, 2'b00);
        load_addrs();
        do_txn(4'b1001, model_pick(4'b1001), 0, 0, 0, $urandom, 2'b11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
